// File: rtl/fft_energy.sv
// rtl/fft_energy.sv - per-bin FFT energy (re^2 + im^2) pipeline with frame bookkeeping
// Accepts one complex bin every other cycle and emits its energy three edges after acceptance.
module fft_energy #(
   parameter int ENRGY_DATA_WIDTH = 40,
   parameter int FFT_DATA_WIDTH   = 32
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [24:0]                 num_fft_pts,
   input  logic [FFT_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        s_axis_tlast,
   output logic                        s_axis_tready,
   output logic [ENRGY_DATA_WIDTH-1:0] energy,
   output logic                        e_ready,
   output logic                        e_last,
   output logic                        frame_err,
   output logic [15:0]                 frame_cnt
);

   logic                        r_tready;
   logic [24:0]                 r_bin;
   logic                        r_frame_err;
   logic [15:0]                 r_frame_cnt;

   logic                        r_in_valid;
   logic [31:0]                 r_in_data;
   logic                        r_in_last;

   logic                        r_s1_valid;
   logic signed [15:0]          r_s1_re;
   logic signed [15:0]          r_s1_im;
   logic                        r_s1_last;

   logic                        r_s2_valid;
   logic [31:0]                 r_re_sq;
   logic [31:0]                 r_im_sq;
   logic                        r_s2_last;

   logic                        r_e_ready;
   logic                        r_e_last;
   logic [ENRGY_DATA_WIDTH-1:0] r_energy;

   logic                        w_accept;
   logic [24:0]                 w_npts_m1;
   logic                        w_at_end;
   logic                        w_last;
   logic signed [31:0]          w_re_sq;
   logic signed [31:0]          w_im_sq;
   logic [32:0]                 w_sum;

   assign w_accept  = s_axis_tvalid & r_tready;
   // A zero frame length behaves as a one-bin frame.
   assign w_npts_m1 = (num_fft_pts == 25'd0) ? 25'd0 : num_fft_pts - 25'd1;
   assign w_at_end  = (r_bin == w_npts_m1);
   assign w_last    = s_axis_tlast | w_at_end;

   assign w_re_sq   = r_s1_re * r_s1_re;
   assign w_im_sq   = r_s1_im * r_s1_im;
   assign w_sum     = {1'b0, r_re_sq} + {1'b0, r_im_sq};

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_tready    <= 1'b0;
         r_bin       <= 25'd0;
         r_frame_err <= 1'b0;
         r_frame_cnt <= 16'd0;
         r_in_valid  <= 1'b0;
         r_in_data   <= 32'd0;
         r_in_last   <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_re     <= 16'sd0;
         r_s1_im     <= 16'sd0;
         r_s1_last   <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_re_sq     <= 32'd0;
         r_im_sq     <= 32'd0;
         r_s2_last   <= 1'b0;
         r_e_ready   <= 1'b0;
         r_e_last    <= 1'b0;
         r_energy    <= '0;
      end else begin
         // One idle cycle after every accepted beat paces the downstream accumulator.
         r_tready <= ~w_accept;

         if (w_accept) begin
            r_bin <= w_last ? 25'd0 : r_bin + 25'd1;
            if (s_axis_tlast != w_at_end) begin
               r_frame_err <= 1'b1;
            end
         end

         r_in_valid <= w_accept;
         if (w_accept) begin
            r_in_data <= s_axis_tdata[31:0];
            r_in_last <= w_last;
         end

         r_s1_valid <= r_in_valid;
         if (r_in_valid) begin
            r_s1_re   <= r_in_data[15:0];
            r_s1_im   <= r_in_data[31:16];
            r_s1_last <= r_in_last;
         end

         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_re_sq   <= w_re_sq;
            r_im_sq   <= w_im_sq;
            r_s2_last <= r_s1_last;
         end

         r_e_ready <= r_s2_valid;
         r_e_last  <= r_s2_valid & r_s2_last;
         if (r_s2_valid) begin
            r_energy <= ENRGY_DATA_WIDTH'(w_sum);
         end

         if (r_e_ready && r_e_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign s_axis_tready = r_tready;
   assign energy        = r_energy;
   assign e_ready       = r_e_ready;
   assign e_last        = r_e_last;
   assign frame_err     = r_frame_err;
   assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_fft_energy.sv
// tb/tb_fft_energy.sv - scoreboard bench for fft_energy with directed vectors
module tb_fft_energy;

   logic        aclk = 1'b0;
   logic        areset;
   logic [24:0] num_fft_pts;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic [39:0] energy;
   logic        e_ready;
   logic        e_last;
   logic        frame_err;
   logic [15:0] frame_cnt;

   fft_energy #(
      .ENRGY_DATA_WIDTH(40),
      .FFT_DATA_WIDTH  (32)
   ) dut (
      .aclk         (aclk),
      .areset       (areset),
      .num_fft_pts  (num_fft_pts),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .energy       (energy),
      .e_ready      (e_ready),
      .e_last       (e_last),
      .frame_err    (frame_err),
      .frame_cnt    (frame_cnt)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      logic [39:0] e;
      logic        l;
      int          c;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one beat; called just after a rising edge, returns just after the accepting edge.
   task automatic send(input int re, input int im, input logic last,
                       input logic [39:0] e_exp, input logic l_exp, input bit push);
      bit   done = 1'b0;
      exp_t it;
      s_axis_tdata  = {im[15:0], re[15:0]};
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      for (int k = 0; k < 8 && !done; k++) begin
         if (s_axis_tready) done = 1'b1;
         @(posedge aclk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL accept_timeout: got no acceptance expected acceptance within 8 cycles");
      end else begin
         if (push) begin
            it.e = e_exp;
            it.l = l_exp;
            it.c = cyc;
            q.push_back(it);
         end
         chk("tready_after_accept", 64'(s_axis_tready), 64'd0);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && q.size() != 0; k++) begin
         @(posedge aclk);
         #1;
      end
      chk("drain_pending", 64'(q.size()), 64'd0);
      repeat (3) @(posedge aclk);
      #1;
   endtask

   // Monitor: every energy strobe must match the oldest outstanding expectation, 3 edges after acceptance.
   initial begin
      exp_t it;
      forever begin
         @(negedge aclk);
         if (e_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_e_ready", 64'(energy), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               it = q.pop_front();
               chk("energy", 64'(energy), 64'(it.e));
               chk("e_last", 64'(e_last), 64'(it.l));
               chk("latency", 64'(cyc - it.c), 64'd3);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected completion before 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] burst_e [8];
      logic [39:0] frame_e [4];
      burst_e = '{40'd5, 40'd20, 40'd45, 40'd80, 40'd125, 40'd180, 40'd245, 40'd320};
      frame_e = '{40'd1, 40'd5, 40'd13, 40'd25};

      areset        = 1'b1;
      num_fft_pts   = 25'd0;
      s_axis_tdata  = 32'd0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_tready",    64'(s_axis_tready), 64'd0);
      chk("rst_e_ready",   64'(e_ready),       64'd0);
      chk("rst_e_last",    64'(e_last),        64'd0);
      chk("rst_frame_err", 64'(frame_err),     64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt),     64'd0);
      chk("rst_energy",    64'(energy),        64'd0);
      areset = 1'b0;
      @(posedge aclk);
      #1;
      chk("tready_after_reset", 64'(s_axis_tready), 64'd1);

      // Single beats with num_fft_pts=0 (one-bin frames)
      send(3, 4, 1'b1, 40'd25, 1'b1, 1'b1);
      drain();
      chk("energy_hold", 64'(energy), 64'd25);
      chk("frame_cnt_single", 64'(frame_cnt), 64'd1);

      send(-32768, -32768, 1'b1, 40'h00_8000_0000, 1'b1, 1'b1);
      send(0, 0, 1'b1, 40'd0, 1'b1, 1'b1);
      send(32767, -32768, 1'b1, 40'd2147418113, 1'b1, 1'b1);
      send(-1, 1, 1'b1, 40'd2, 1'b1, 1'b1);
      drain();
      chk("frame_cnt_extremes", 64'(frame_cnt), 64'd5);
      chk("frame_err_extremes", 64'(frame_err), 64'd0);

      // Back-to-back burst of 8 beats forming one frame
      num_fft_pts = 25'd8;
      for (int i = 0; i < 8; i++) begin
         send(i + 1, 2 * (i + 1), (i == 7), burst_e[i], (i == 7), 1'b1);
      end
      drain();
      chk("frame_cnt_burst", 64'(frame_cnt), 64'd6);
      chk("frame_err_burst", 64'(frame_err), 64'd0);

      // Three well-formed 4-bin frames after a fresh reset
      areset = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      @(posedge aclk);
      #1;
      num_fft_pts = 25'd4;
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < 4; b++) begin
            send(b + 1, b, (b == 3), frame_e[b], (b == 3), 1'b1);
         end
      end
      drain();
      chk("frame_cnt_frames", 64'(frame_cnt), 64'd3);
      chk("frame_err_frames", 64'(frame_err), 64'd0);

      // Early tlast on bin 2, then a full frame restarting at bin 0
      for (int b = 0; b < 3; b++) begin
         send(b + 1, b, (b == 2), frame_e[b], (b == 2), 1'b1);
      end
      drain();
      chk("frame_err_early", 64'(frame_err), 64'd1);
      for (int b = 0; b < 4; b++) begin
         send(b + 1, b, (b == 3), frame_e[b], (b == 3), 1'b1);
      end
      drain();
      chk("frame_err_sticky", 64'(frame_err), 64'd1);
      chk("frame_cnt_mismatch", 64'(frame_cnt), 64'd5);

      // Missing tlast: counter end still marks the frame boundary
      num_fft_pts = 25'd2;
      send(5, 0, 1'b0, 40'd25, 1'b0, 1'b1);
      send(0, 5, 1'b0, 40'd25, 1'b1, 1'b1);
      drain();
      chk("frame_cnt_missing_tlast", 64'(frame_cnt), 64'd6);
      chk("frame_err_missing_tlast", 64'(frame_err), 64'd1);

      // Reset with two beats in flight discards them
      send(7, 0, 1'b0, 40'd49, 1'b0, 1'b0);
      send(0, 9, 1'b0, 40'd81, 1'b0, 1'b0);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      chk("inflight_e_ready",   64'(e_ready),       64'd0);
      chk("inflight_e_last",    64'(e_last),        64'd0);
      chk("inflight_energy",    64'(energy),        64'd0);
      chk("inflight_frame_err", 64'(frame_err),     64'd0);
      chk("inflight_frame_cnt", 64'(frame_cnt),     64'd0);
      chk("inflight_tready",    64'(s_axis_tready), 64'd0);
      areset = 1'b0;
      @(posedge aclk);
      #1;
      chk("tready_after_inflight_reset", 64'(s_axis_tready), 64'd1);
      repeat (10) @(posedge aclk);
      #1;
      chk("energy_after_inflight_reset", 64'(energy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_energy.md
FFT_ENERGY -- requirements
Module: fft_energy

Interface
REQ-001 Parameter ENRGY_DATA_WIDTH, default 40, width of the energy output.
REQ-002 Parameter FFT_DATA_WIDTH, default 32, width of the FFT bin input; bits [15:0] carry re and [31:16] carry im, both signed two's complement.
REQ-003 aclk  input  1  single clock; all logic updates on the rising edge.
REQ-004 areset  input  1  reset, synchronous and active-high.
REQ-005 num_fft_pts  input  25  bins per frame; a value of 0 SHALL be treated as 1.
REQ-006 s_axis_tdata  input  FFT_DATA_WIDTH  FFT bin, complex.
REQ-007 s_axis_tvalid  input  1  upstream beat valid.
REQ-008 s_axis_tlast  input  1  upstream last bin of frame.
REQ-009 s_axis_tready  output  1  block can accept a beat.
REQ-010 energy  output  ENRGY_DATA_WIDTH  re^2 + im^2, zero-extended.
REQ-011 e_ready  output  1  one-cycle strobe; energy is valid in this cycle.
REQ-012 e_last  output  1  high with e_ready when the energy belongs to the last bin of a frame.
REQ-013 frame_err  output  1  sticky error flag for a tlast/bin-count mismatch.
REQ-014 frame_cnt  output  16  number of completed frames at the output, wrapping.

Function
REQ-015 A beat SHALL be accepted on a rising edge where s_axis_tvalid and s_axis_tready are both high.
REQ-016 s_axis_tready SHALL be low in the cycle immediately after an accepted beat and high otherwise, limiting throughput to 1 beat per 2 cycles.
- Reason: the downstream accumulator needs at least 2 cycles per e_ready.
REQ-017 Pipeline, 3 register stages:
- S1: capture re, im, and the last flag.
- S2: register re*re and im*im, each 32-bit unsigned.
- S3: register their 33-bit sum into energy, and assert e_ready and e_last.
REQ-018 Latency: e_ready SHALL be high in the cycle beginning on the 3rd rising edge after the accepting edge.
REQ-019 e_ready SHALL be high for exactly one cycle per accepted beat; results SHALL appear in acceptance order; no beat SHALL be dropped or duplicated.
REQ-020 energy SHALL hold its last value when e_ready is low.
REQ-021 Arithmetic: full-precision signed squares with no saturation; the maximum, re=im=-32768, gives 2^31 exactly; upper energy bits SHALL be zero.
REQ-022 A bin counter SHALL increment on each accepted beat.
REQ-023 The bin counter SHALL return to 0 on an accepted beat with s_axis_tlast high, or on a beat where the counter equals num_fft_pts-1.
REQ-024 frame_err SHALL set on an accepted beat under either condition:
- tlast is high while the counter is not num_fft_pts-1;
- tlast is low while the counter equals num_fft_pts-1.
REQ-025 Once set, frame_err SHALL remain set until reset.
REQ-026 The last flag carried through the pipeline SHALL be (tlast OR counter == num_fft_pts-1), so e_last still marks frame boundaries after a mismatch.
REQ-027 frame_cnt SHALL increment on every cycle with e_ready and e_last both high, and SHALL wrap from 0xFFFF to 0.
REQ-028 A change of num_fft_pts mid-frame SHALL take effect on the next comparison; no special handling is required beyond REQ-023/REQ-024.

Reset
REQ-029 While areset is high on a rising edge, the following SHALL be 0:
- s_axis_tready, e_ready, e_last, frame_err;
- frame_cnt, energy, the bin counter;
- all pipeline valid bits.
REQ-030 s_axis_tready SHALL be high in the first cycle after areset is sampled low.
REQ-031 Reset during operation SHALL discard in-flight beats; no e_ready SHALL be produced for beats accepted before the reset edge.

Verification
REQ-032 Single beat: re=3, im=4 accepted at edge N -> energy=25 with e_ready high in exactly one cycle, after edge N+3.
REQ-033 Extremes: re=-32768, im=-32768 -> energy=0x0080000000; re=0, im=0 -> energy=0 with e_ready still strobed.
REQ-034 Continuous tvalid for 8 beats -> tready pattern 1,0,1,0,...; e_ready strobes 2 cycles apart; 8 results in input order.
REQ-035 num_fft_pts=4, tlast on the 4th beat for 3 frames -> e_last on every 4th e_ready; frame_cnt=3; frame_err=0.
REQ-036 Mismatch: num_fft_pts=4, tlast on the 3rd beat -> frame_err=1 and stays 1; the next frame starts at bin 0.
REQ-037 areset pulsed for 1 cycle with 2 beats in flight -> no e_ready afterwards; all outputs 0; tready=1 in the following cycle.
